// File: rtl/multicycle_addsub.sv
// Chunk-serial adder/subtractor: CHUNK bits per clock, N = WIDTH/CHUNK cycles per operation.
// Optional carry/borrow-in port enabled by defining ADDSUB_CARRY_IN_EN.
module multicycle_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             sub,
`ifdef ADDSUB_CARRY_IN_EN
  input  logic             cin,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  acc;
  logic              cy;
  logic [CW-1:0]     cnt;

  logic [CHUNK-1:0]  a_ch;
  logic [CHUNK-1:0]  b_ch;
  logic [CHUNK:0]    sum;
  logic [WIDTH-1:0]  acc_nxt;
  logic              c0;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
  function automatic logic ovf_flag(input logic xm, input logic ym,
                                    input logic [CHUNK:0] s);
    return (xm ^ ym ^ s[CHUNK-1]) ^ s[CHUNK];
  endfunction

  always_comb begin
    a_ch    = a_r[cnt*CHUNK +: CHUNK];
    b_ch    = b_r[cnt*CHUNK +: CHUNK];
    sum     = chunk_add(a_ch, b_ch, cy);
    acc_nxt = acc;
    acc_nxt[cnt*CHUNK +: CHUNK] = sum[CHUNK-1:0];
`ifdef ADDSUB_CARRY_IN_EN
    c0 = sub ? ~cin : cin;
`else
    c0 = sub;
`endif
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= A;
            b_r   <= sub ? ~B : B;
            cy    <= c0;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cy  <= sum[CHUNK];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result    <= acc_nxt;
            carry_out <= sum[CHUNK];
            overflow  <= ovf_flag(a_ch[CHUNK-1], b_ch[CHUNK-1], sum);
            zero      <= (acc_nxt == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Randomised self-checking bench for multicycle_addsub against an integer-arithmetic model.
module tb_multicycle_addsub;
  localparam int W  = 32;
  localparam int CH = 8;
  localparam int N  = W / CH;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          sub   = 1'b0;
  logic          cin   = 1'b0;
  logic [W-1:0]  A     = '0;
  logic [W-1:0]  B     = '0;
  logic          busy, done, carry_out, overflow, zero;
  logic [W-1:0]  result;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_addsub #(.WIDTH(W), .CHUNK(CH)) dut (
    .clock(clock), .clear(clear), .start(start), .sub(sub),
`ifdef ADDSUB_CARRY_IN_EN
    .cin(cin),
`endif
    .A(A), .B(B), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  // Reference: plain signed/unsigned integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic ci);
    exp_t   e;
    longint ua, ub, ud, sa, sb, sd, k;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`ifdef ADDSUB_CARRY_IN_EN
    k = ci ? 1 : 0;
`else
    k = 0;
`endif
    if (s) begin
      ud  = ua - ub - k;
      sd  = sa - sb - k;
      e.c = (ud >= 0);
    end else begin
      ud  = ua + ub + k;
      sd  = sa + sb + k;
      e.c = (ud >= (longint'(1) <<< W));
    end
    e.r = ud[W-1:0];
    e.v = (sd > ((longint'(1) <<< (W-1)) - 1)) || (sd < -(longint'(1) <<< (W-1)));
    e.z = (e.r == '0);
    return e;
  endfunction

  // Drives one operation and waits (bounded) for done; returns latency and busy observation.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic ci, output int lat, output logic busy_ok);
    A = a; B = b; sub = s; cin = ci; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if ({busy, done, result, carry_out, overflow, zero} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got busy=%b done=%b result=%h c=%b v=%b z=%b expected all 0",
               busy, done, result, carry_out, overflow, zero);
    end
    clear = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] av [6] = '{32'd5, 32'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h80000000};
    logic [W-1:0] bv [6] = '{32'd3, 32'd5, 32'd1,        32'd1,        32'h1234, 32'd1};
    logic         sv [6] = '{1'b1,  1'b1,  1'b0,         1'b0,         1'b1,     1'b1};
    exp_t         ev [6] = '{
      '{r: 32'd2,        c: 1'b1, v: 1'b0, z: 1'b0},
      '{r: 32'hFFFFFFFE, c: 1'b0, v: 1'b0, z: 1'b0},
      '{r: 32'h80000000, c: 1'b0, v: 1'b1, z: 1'b0},
      '{r: 32'h00000000, c: 1'b1, v: 1'b0, z: 1'b1},
      '{r: 32'h00000000, c: 1'b1, v: 1'b0, z: 1'b1},
      '{r: 32'h7FFFFFFF, c: 1'b1, v: 1'b1, z: 1'b0}};
    int   lat;
    logic bok;
    for (int i = 0; i < 6; i++) begin
      run_op(av[i], bv[i], sv[i], 1'b0, lat, bok);
      tests_run++;
      if (lat !== N || bok !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed%0d_timing got lat=%0d busy_during=%b busy_at_done=%b expected lat=%0d 1 0",
                 i, lat, bok, busy, N);
      end
      tests_run++;
      if ({result, carry_out, overflow, zero} !== ev[i]) begin
        tests_failed++;
        $display("FAIL directed%0d_value got r=%h c=%b v=%b z=%b expected r=%h c=%b v=%b z=%b",
                 i, result, carry_out, overflow, zero, ev[i].r, ev[i].c, ev[i].v, ev[i].z);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corner [5] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h1};
    logic [W-1:0] a, b;
    logic         s, ci;
    exp_t         e;
    int           lat;
    logic         bok;
    for (int i = 0; i < 30; i++) begin
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      s  = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      e  = model(a, b, s, ci);
      run_op(a, b, s, ci, lat, bok);
      tests_run++;
      if (lat !== N || bok !== 1'b1 || {result, carry_out, overflow, zero} !== e) begin
        tests_failed++;
        $display("FAIL random%0d a=%h b=%h sub=%b cin=%b got lat=%0d busy=%b r=%h c=%b v=%b z=%b expected lat=%0d r=%h c=%b v=%b z=%b",
                 i, a, b, s, ci, lat, bok, result, carry_out, overflow, zero, N, e.r, e.c, e.v, e.z);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] r0;
    int           lat;
    logic         bok;
    run_op(32'd100, 32'd1, 1'b1, 1'b0, lat, bok);
    r0 = result;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd99 || r0 !== 32'd99) begin
      tests_failed++;
      $display("FAIL hold got done=%b busy=%b result=%h at_done=%h expected 0 0 63 63",
               done, busy, result, r0);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    A = 32'd5; B = 32'd3; sub = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    lat = 0;
    while (!done && lat < 20) begin
      A = W'($urandom); B = W'($urandom); sub = ~sub;
      start = (lat < N - 1);
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    tests_run++;
    if (lat !== N || result !== 32'd2 || carry_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_ignored got lat=%0d result=%h c=%b expected lat=%0d result=2 c=1",
               lat, result, carry_out, N);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    logic bok;
    run_op(32'd10, 32'd20, 1'b0, 1'b0, lat, bok);
    tests_run++;
    if (done !== 1'b1 || result !== 32'd30) begin
      tests_failed++;
      $display("FAIL b2b_first got done=%b result=%h expected 1 1e", done, result);
    end
    e = model(32'hDEADBEEF, 32'h0BADF00D, 1'b1, 1'b0);
    run_op(32'hDEADBEEF, 32'h0BADF00D, 1'b1, 1'b0, lat, bok);
    tests_run++;
    if (lat !== N || bok !== 1'b1 || {result, carry_out, overflow, zero} !== e) begin
      tests_failed++;
      $display("FAIL b2b_second got lat=%0d busy=%b r=%h c=%b v=%b z=%b expected lat=%0d r=%h c=%b v=%b z=%b",
               lat, bok, result, carry_out, overflow, zero, N, e.r, e.c, e.v, e.z);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_abort();
    logic saw_done;
    int   lat;
    logic bok;
    A = 32'd7; B = 32'd9; sub = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    clear = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if ({busy, done, result, carry_out, overflow, zero} !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs got busy=%b done=%b result=%h c=%b v=%b z=%b expected all 0",
               busy, done, result, carry_out, overflow, zero);
    end
    clear = 1'b1;
    saw_done = 1'b0;
    repeat (N + 2) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done got activity=%b expected 0", saw_done);
    end
    run_op(32'd40, 32'd2, 1'b0, 1'b0, lat, bok);
    tests_run++;
    if (lat !== N || result !== 32'd42) begin
      tests_failed++;
      $display("FAIL abort_recover got lat=%0d result=%h expected lat=%0d result=2a", lat, result, N);
    end
    @(posedge clock); #1;
  endtask

`ifdef ADDSUB_CARRY_IN_EN
  task automatic test_carry_in();
    int   lat;
    logic bok;
    run_op(32'd0, 32'd0, 1'b0, 1'b1, lat, bok);
    tests_run++;
    if (result !== 32'd1) begin
      tests_failed++;
      $display("FAIL cin_add got result=%h expected 1", result);
    end
    run_op(32'd5, 32'd3, 1'b1, 1'b1, lat, bok);
    tests_run++;
    if (result !== 32'd1) begin
      tests_failed++;
      $display("FAIL cin_sub got result=%h expected 1", result);
    end
    @(posedge clock); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_start_ignored();
    test_back_to_back();
    test_abort();
`ifdef ADDSUB_CARRY_IN_EN
    test_carry_in();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
